// File: rtl/sseg_scan_driver.sv
// rtl/sseg_scan_driver.sv - 4-digit multiplexed hex display scanner with frame-boundary shadow load
module sseg_scan_driver #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] disp_data,
  input  logic        half_sel,
  input  logic        load_en,
  input  logic [3:0]  dp_mask,
  input  logic        blank_lz,
  output logic [3:0]  top_an,
  output logic [7:0]  top_sseg,
  output logic        frame_done
);

  localparam int CNT_W = $clog2(REFRESH_DIV) + 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] prescaler;
  logic [1:0]       digit_idx;
  logic [31:0]      shadow_data;
  logic             shadow_half;
  logic             first_edge;

  logic             terminal;
  logic             wrap;
  logic             do_load;
  logic [15:0]      half_word;
  logic [3:0]       nib;
  logic             blank;
  logic [3:0]       an_next;
  logic [7:0]       sseg_next;

  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_seg = 7'h40;
      4'h1: hex_seg = 7'h79;
      4'h2: hex_seg = 7'h24;
      4'h3: hex_seg = 7'h30;
      4'h4: hex_seg = 7'h19;
      4'h5: hex_seg = 7'h12;
      4'h6: hex_seg = 7'h02;
      4'h7: hex_seg = 7'h78;
      4'h8: hex_seg = 7'h00;
      4'h9: hex_seg = 7'h10;
      4'hA: hex_seg = 7'h08;
      4'hB: hex_seg = 7'h03;
      4'hC: hex_seg = 7'h46;
      4'hD: hex_seg = 7'h21;
      4'hE: hex_seg = 7'h06;
      default: hex_seg = 7'h0E;
    endcase
  endfunction

  assign terminal = (prescaler == TERM);
  assign wrap     = terminal && (digit_idx == 2'd3);
  // The very first edge after reset also loads, so valid data appears without a frame of delay.
  assign do_load  = load_en && (wrap || first_edge);

  always_comb begin
    half_word = shadow_half ? shadow_data[31:16] : shadow_data[15:0];
    nib       = 4'h0;
    blank     = 1'b0;
    case (digit_idx)
      2'd0: nib = half_word[3:0];
      2'd1: begin
        nib   = half_word[7:4];
        blank = blank_lz && (half_word[15:4] == 12'h000);
      end
      2'd2: begin
        nib   = half_word[11:8];
        blank = blank_lz && (half_word[15:8] == 8'h00);
      end
      default: begin
        nib   = half_word[15:12];
        blank = blank_lz && (half_word[15:12] == 4'h0);
      end
    endcase
    if (blank) begin
      an_next   = 4'b1111;
      sseg_next = 8'hFF;
    end else begin
      an_next   = ~(4'b0001 << digit_idx);
      sseg_next = {~dp_mask[digit_idx], hex_seg(nib)};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler   <= '0;
      digit_idx   <= 2'd0;
      shadow_data <= 32'h0;
      shadow_half <= 1'b0;
      first_edge  <= 1'b1;
      top_an      <= 4'b1111;
      top_sseg    <= 8'hFF;
      frame_done  <= 1'b0;
    end else begin
      first_edge <= 1'b0;
      prescaler  <= terminal ? '0 : prescaler + 1'b1;
      if (terminal) begin
        digit_idx <= digit_idx + 2'd1;
      end
      if (do_load) begin
        shadow_data <= disp_data;
        shadow_half <= half_sel;
      end
      frame_done <= wrap;
      top_an     <= an_next;
      top_sseg   <= sseg_next;
    end
  end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// tb/tb_sseg_scan_driver.sv - directed table-driven bench for sseg_scan_driver
module tb_sseg_scan_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] disp_data = 32'h0;
  logic        half_sel = 1'b0;
  logic        load_en = 1'b1;
  logic [3:0]  dp_mask = 4'h0;
  logic        blank_lz = 1'b0;
  logic [3:0]  top_an;
  logic [7:0]  top_sseg;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  sseg_scan_driver #(.REFRESH_DIV(4)) dut (
    .clk(clk), .reset(reset), .disp_data(disp_data), .half_sel(half_sel),
    .load_en(load_en), .dp_mask(dp_mask), .blank_lz(blank_lz),
    .top_an(top_an), .top_sseg(top_sseg), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]     data;
    logic            half;
    logic            blank;
    logic [3:0]      dp;
    logic [3:0][7:0] seg;
    logic [3:0][3:0] an;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start(input logic [31:0] d, input logic h, input logic b, input logic [3:0] dp);
    @(negedge clk);
    reset     = 1'b1;
    disp_data = d;
    half_sel  = h;
    blank_lz  = b;
    dp_mask   = dp;
    load_en   = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'h0000_1234, 1'b0, 1'b0, 4'h0, {8'hF9, 8'hA4, 8'hB0, 8'h99}, {4'h7, 4'hB, 4'hD, 4'hE}};
    vecs[1] = '{32'hABCD_0001, 1'b1, 1'b0, 4'h0, {8'h88, 8'h83, 8'hC6, 8'hA1}, {4'h7, 4'hB, 4'hD, 4'hE}};
    vecs[2] = '{32'h0000_0005, 1'b0, 1'b1, 4'h0, {8'hFF, 8'hFF, 8'hFF, 8'h92}, {4'hF, 4'hF, 4'hF, 4'hE}};
    vecs[3] = '{32'h0000_0000, 1'b0, 1'b1, 4'h0, {8'hFF, 8'hFF, 8'hFF, 8'hC0}, {4'hF, 4'hF, 4'hF, 4'hE}};
    vecs[4] = '{32'h0000_8888, 1'b0, 1'b0, 4'b0100, {8'h80, 8'h00, 8'h80, 8'h80}, {4'h7, 4'hB, 4'hD, 4'hE}};
    vecs[5] = '{32'h0000_0018, 1'b0, 1'b0, 4'h0, {8'hC0, 8'hC0, 8'hF9, 8'h80}, {4'h7, 4'hB, 4'hD, 4'hE}};
    vecs[6] = '{32'h0000_0005, 1'b0, 1'b1, 4'hF, {8'hFF, 8'hFF, 8'hFF, 8'h12}, {4'hF, 4'hF, 4'hF, 4'hE}};
    vecs[7] = '{32'h0123_0000, 1'b1, 1'b1, 4'h0, {8'hFF, 8'hF9, 8'hA4, 8'hB0}, {4'hF, 4'hB, 4'hD, 4'hE}};
    vecs[8] = '{32'hABCD_0001, 1'b0, 1'b1, 4'h0, {8'hFF, 8'hFF, 8'hFF, 8'hF9}, {4'hF, 4'hF, 4'hF, 4'hE}};

    // Reset state with clock toggling
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_an", 32'(top_an), 32'hF);
    check("rst_sseg", 32'(top_sseg), 32'hFF);
    check("rst_fd", 32'(frame_done), 32'h0);

    // Table: first edge loads shadow, so digit d is valid after edge 4d+2 through 4d+4
    foreach (vecs[i]) begin
      start(vecs[i].data, vecs[i].half, vecs[i].blank, vecs[i].dp);
      for (int k = 1; k <= 16; k++) begin
        int d;
        @(posedge clk);
        @(negedge clk);
        d = (k - 1) / 4;
        if (k >= 2) begin
          check($sformatf("v%0d_an_k%0d", i, k), 32'(top_an), 32'(vecs[i].an[d]));
          check($sformatf("v%0d_sseg_k%0d", i, k), 32'(top_sseg), 32'(vecs[i].seg[d]));
        end
        check($sformatf("v%0d_fd_k%0d", i, k), 32'(frame_done), (k == 16) ? 32'h1 : 32'h0);
      end
    end

    // Mid-scan asynchronous reset
    start(32'h0000_1234, 1'b0, 1'b0, 4'h0);
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("pre_rst_an", 32'(top_an), 32'hD);
    reset = 1'b1;
    #1;
    check("async_rst_an", 32'(top_an), 32'hF);
    check("async_rst_sseg", 32'(top_sseg), 32'hFF);
    check("async_rst_fd", 32'(frame_done), 32'h0);

    // half_sel change mid-frame takes effect only after the wrap
    start(32'hABCD_0001, 1'b1, 1'b0, 4'h0);
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 6) half_sel = 1'b0;
      if (k == 10) check("hs_d2", 32'(top_sseg), 32'h83);
      if (k == 14) check("hs_d3", 32'(top_sseg), 32'h88);
      if (k == 16) begin
        check("hs_d3_wrap", 32'(top_sseg), 32'h88);
        check("hs_fd", 32'(frame_done), 32'h1);
      end
      if (k == 17) begin
        check("hs_new_an", 32'(top_an), 32'hE);
        check("hs_new_sseg", 32'(top_sseg), 32'hF9);
      end
    end

    // Freeze: shadow keeps 00F0 after load_en drops; frame_done period is 16 clks
    begin
      int pulses = 0;
      start(32'h0000_00F0, 1'b0, 1'b0, 4'h0);
      for (int k = 1; k <= 48; k++) begin
        @(posedge clk);
        @(negedge clk);
        if (k == 1) begin
          load_en   = 1'b0;
          disp_data = 32'h0000_FFFF;
        end
        if (frame_done) begin
          pulses++;
          check($sformatf("fz_fd_at_k%0d", k), 32'(k % 16), 32'h0);
        end
        if (k == 18) check("fz_d0", 32'(top_sseg), 32'hC0);
        if (k == 22) check("fz_d1", 32'(top_sseg), 32'h8E);
        if (k == 26) check("fz_d2", 32'(top_sseg), 32'hC0);
        if (k == 30) check("fz_d3", 32'(top_sseg), 32'hC0);
      end
      check("fz_pulses", 32'(pulses), 32'd3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
